// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: CHUNK bits per cycle, LSB chunk first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("cla_seq_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry;
    logic [IW-1:0]     idx;
    logic              last_chunk;

    logic [CHUNK-1:0]  ca;
    logic [CHUNK-1:0]  cb;
    logic [CHUNK-1:0]  g;
    logic [CHUNK-1:0]  p;
    logic [CHUNK:0]    c;
    logic [CHUNK-1:0]  csum;
    logic              cj;
    logic              term;

    always_comb begin
        ca = '0;
        cb = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                ca = a_r[k*CHUNK +: CHUNK];
                cb = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    assign last_chunk = (idx == IW'(NCHUNK - 1));

    // Each carry is a flat sum of products of G/P and the carry register, not a ripple chain.
    always_comb begin
        g    = ca & cb;
        p    = ca | cb;
        c    = '0;
        cj   = 1'b0;
        term = 1'b0;
        c[0] = carry;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            cj = carry;
            for (int unsigned k = 0; k <= j; k++) begin
                cj = cj & p[k];
            end
            for (int unsigned k = 0; k <= j; k++) begin
                term = g[k];
                for (int unsigned m = k + 1; m <= j; m++) begin
                    term = term & p[m];
                end
                cj = cj | term;
            end
            c[j+1] = cj;
        end
        csum = ca ^ cb ^ c[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
`ifdef CLA_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= cin ^ sub;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k)) begin
                            sum[k*CHUNK +: CHUNK] <= csum;
                        end
                    end
                    carry <= c[CHUNK];
                    if (last_chunk) begin
                        cout  <= c[CHUNK];
`ifdef CLA_SEQ_OVF_EN
                        ovf   <= c[CHUNK] ^ c[CHUNK-1];
`endif
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle only raises out_valid; this sets the accept-to-valid latency to NCHUNK+1.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed test-plan steps plus random operations against an arithmetic model.
module tb_cla_seq_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
    logic         in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1;
    logic [W-1:0] a1, b1, sum1;
`ifdef CLA_SEQ_OVF_EN
    logic         ovf, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    cla_seq_adder #(.WIDTH(W), .CHUNK(4)) dut (
`ifdef CLA_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    cla_seq_adder #(.WIDTH(W), .CHUNK(32)) dut1 (
`ifdef CLA_SEQ_OVF_EN
        .ovf(ovf1),
`endif
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic; sub is a - b - cin, cout is carry (add) or no-borrow (sub).
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s,
                         output logic [31:0] es, output logic ec, output logic eo);
        longint ux, uy, sx, sy, ures, sres;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            ures = ux - uy - longint'(ci);
            sres = sx - sy - longint'(ci);
            ec   = (ures >= 0);
        end else begin
            ures = ux + uy + longint'(ci);
            sres = sx + sy + longint'(ci);
            ec   = (ures >= 64'sd4294967296);
        end
        es = ures[31:0];
        eo = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tc, input logic ts,
                          input int hold, input string tag);
        logic [31:0] es;
        logic        ec, eo;
        int          n;
        model(ta, tbv, tc, ts, es, ec, eo);
        n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1; out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        chk({tag, "_busy"}, in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, W / 4 + 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
`ifdef CLA_SEQ_OVF_EN
        chk({tag, "_ovf"}, ovf, eo);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_sum"}, sum, es);
            chk({tag, "_hold_cout"}, cout, ec);
            chk({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] es;
        logic        ec, eo;
        int          n;
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;

        // Reset with in_valid asserted: reset wins, nothing is accepted.
        @(negedge clk);
        in_valid = 1'b1; a = 32'h1234; b = 32'h1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "t1_wrap");
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 0, "t2_borrow");
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 0, "t2_noborrow");
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 5, "t3_backpressure");

        // Reset during the third CALC cycle aborts the operation.
        a = 32'h0F0F_0F0F; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_ready", in_ready, 1);
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_sum", sum, 0);
        chk("t4_rst_cout", cout, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("t4_no_result", seen, 0);
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, "t4_after");

`ifdef CLA_SEQ_OVF_EN
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0, "t5_ovf_add");
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 0, "t5_ovf_sub");
        run_op(32'd2, 32'd3, 1'b0, 1'b0, 0, "t5_no_ovf");
`endif

        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        // Single-chunk instance: one CALC cycle.
        model(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, es, ec, eo);
        chk("t6_model_sum", es, 32'h2345_678A);
        chk("t6_ready", in_ready1, 1);
        a1 = 32'h1234_5678; b1 = 32'h1111_1111; cin1 = 1'b1; sub1 = 1'b0; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 0;
        while (out_valid1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_latency", n, 2);
        chk("t6_sum", sum1, es);
        chk("t6_cout", cout1, ec);
`ifdef CLA_SEQ_OVF_EN
        chk("t6_ovf", ovf1, eo);
`endif
        @(negedge clk);
        chk("t6_valid_drop", out_valid1, 0);
        chk("t6_idle_ready", in_ready1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
